// File: rtl/piso_tx_sched_if.sv
// piso_tx_sched_if: bundle between the requester blocks, the scheduler and
// the external parallel-in/serial-out shifter.
//
// Handshake: req[i] is a level request. The scheduler samples req only while
// idle. ack pulses for exactly one cycle, in the cycle after the winner's word
// was captured, with gnt naming the winner. After that ack, the requester may
// drop req or change data_in without disturbing the frame in flight. gnt
// stays one-hot until the last bit has been shifted out.
//
// Signals:
//   req      N        request per requester (level)
//   data_in  N*W      requester words; requester i on bits [i*W +: W]
//   gnt      N        one-hot grant, held through LOAD and SHIFT
//   ack      1        one-cycle grant pulse
//   pl       1        shifter parallel-load strobe (1 = load, 0 = shift)
//   a        W        word presented to the shifter
//   frame    1        shifter output carries a valid bit
//   bit_idx  clog2(W) index of the bit on the shifter output, MSB first
//   done     1        one-cycle pulse on the last bit
//   busy     1        scheduler not idle
interface piso_tx_sched_if #(
  parameter int N = 2,
  parameter int W = 4
);
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   gnt;
  logic           ack;
  logic           pl;
  logic [W-1:0]   a;
  logic           frame;
  logic [BW-1:0]  bit_idx;
  logic           done;
  logic           busy;

  // Requester / environment side.
  modport master (
    output req, data_in,
    input  gnt, ack, pl, a, frame, bit_idx, done, busy
  );

  // Scheduler side.
  modport slave (
    input  req, data_in,
    output gnt, ack, pl, a, frame, bit_idx, done, busy
  );
endinterface

// File: rtl/piso_tx_sched.sv
// piso_tx_sched: round-robin scheduler sharing one external W-bit PISO
// shifter among N requesters. It grants one requester at a time, latches the
// winner's word, strobes the shifter load, counts W serial bit times and then
// holds off for GAP guard cycles before serving the next request.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   bus        piso_tx_sched_if.slave (req/data_in in; gnt/ack/pl/a/frame/
//              bit_idx/done/busy out)
//   fsm_state  current FSM state encoding (IDLE=0, LOAD=1, SHIFT=2, GUARD=3)
//
// Every output is decoded from registers only, so nothing on the shifter
// side depends combinationally on req or data_in.
module piso_tx_sched #(
  parameter int N   = 2,
  parameter int W   = 4,
  parameter int GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  piso_tx_sched_if.slave    bus,
  output logic [1:0]        fsm_state
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GUARD = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          found;
  logic [W-1:0]  word;
  logic [BW-1:0] cnt;
  logic [3:0]    gap_cnt;
  logic          last_bit;

  assign last_bit = (cnt == BW'(W - 1));

  // Round-robin search starting just after the last winner; the last winner
  // is visited last, so it only wins again when nobody else is asking.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int i = 1; i <= N; i++) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && bus.req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (found) state_next = LOAD;
      LOAD:  state_next = SHIFT;
      SHIFT: if (last_bit) state_next = (GAP > 0) ? GUARD : IDLE;
      GUARD: if (gap_cnt == 4'(GAP - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: the pointer and word change only on a capture in IDLE, so a
  // frame in flight is immune to later req/data_in activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= PW'(N - 1);
      word    <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          gap_cnt <= '0;
          if (found) begin
            ptr  <= win;
            word <= bus.data_in[int'(win)*W +: W];
          end
        end
        LOAD:  cnt <= '0;
        SHIFT: cnt <= last_bit ? '0 : cnt + 1'b1;
        GUARD: gap_cnt <= gap_cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  assign bus.pl      = (state == LOAD);
  assign bus.ack     = (state == LOAD);
  assign bus.frame   = (state == SHIFT);
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == SHIFT) && last_bit;
  assign bus.bit_idx = (state == SHIFT) ? (BW'(W - 1) - cnt) : '0;
  assign bus.gnt     = ((state == LOAD) || (state == SHIFT)) ? (N'(1) << ptr) : '0;
  assign bus.a       = word;
  assign fsm_state   = state;
endmodule

// File: tb/tb_piso_tx_sched.sv
// Bench for piso_tx_sched: models the external shifter, keeps a queue of
// expected {gnt, word} frames and checks every frame bit by bit.
module tb_piso_tx_sched;
  localparam int N   = 2;
  localparam int W   = 4;
  localparam int GAP = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] fsm_state;

  piso_tx_sched_if #(.N(N), .W(W)) bus();

  piso_tx_sched #(.N(N), .W(W), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [N+W-1:0] exp_q[$];

  // External shifter: load on pl, otherwise shift toward the MSB.
  logic [W-1:0] sreg = '0;
  logic         ser;
  assign ser = sreg[W-1];
  always @(posedge clk) sreg <= bus.pl ? bus.a : {sreg[W-2:0], 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},     32'(bus.gnt), 0);
    check({tag, "_ack"},     32'(bus.ack), 0);
    check({tag, "_pl"},      32'(bus.pl), 0);
    check({tag, "_a"},       32'(bus.a), 0);
    check({tag, "_frame"},   32'(bus.frame), 0);
    check({tag, "_bit_idx"}, 32'(bus.bit_idx), 0);
    check({tag, "_done"},    32'(bus.done), 0);
    check({tag, "_busy"},    32'(bus.busy), 0);
    check({tag, "_state"},   32'(fsm_state), 0);
  endtask

  // Monitor: validates each grant against the queue head and assembles the
  // serial bits of each frame.
  int             col_n       = 0;
  logic [W-1:0]   col_w       = '0;
  int             frames_done = 0;
  int             ack_count   = 0;
  logic [N+W-1:0] head;

  always @(negedge clk) begin
    if (rst) begin
      col_n = 0;
      col_w = '0;
    end else begin
      if (bus.ack) begin
        ack_count++;
        check("ack_pl", 32'(bus.pl), 1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL ack_unexpected observed gnt=%0h expected no grant", bus.gnt);
        end else begin
          check("ack_gnt", 32'(bus.gnt), 32'(exp_q[0][N+W-1:W]));
          check("ack_a",   32'(bus.a),   32'(exp_q[0][W-1:0]));
        end
        col_n = 0;
      end
      if (bus.frame) begin
        check("bit_idx", 32'(bus.bit_idx), 32'(W - 1 - col_n));
        check("done",    32'(bus.done),    32'(col_n == W - 1));
        col_w = {col_w[W-2:0], ser};
        col_n++;
        if (col_n == W) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL frame_unexpected observed word=%0h expected no frame", col_w);
          end else begin
            head = exp_q.pop_front();
            check("frame_gnt",  32'(bus.gnt), 32'(head[N+W-1:W]));
            check("frame_word", 32'(col_w),   32'(head[W-1:0]));
          end
          frames_done++;
          col_n = 0;
        end
      end
    end
  end

  task automatic wait_ack(output int cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ack && n < 50);
    cyc = int'($time / 10);
    if (!bus.ack) begin
      checks++;
      failures++;
      $error("FAIL ack_timeout observed no ack in %0d cycles expected ack", n);
    end
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", 32'(frames_done >= target), 1);
  endtask

  initial begin
    int c0, c1, c2, c3, base, acks;
    bus.req     = '0;
    bus.data_in = '0;

    // Reset state
    #1 rst = 1'b1;
    #1 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single request: 1011 from requester 0
    base = frames_done;
    bus.data_in[0 +: W] = 4'b1011;
    exp_q.push_back({2'b01, 4'b1011});
    bus.req = 2'b01;
    wait_ack(c0);
    bus.req = '0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check("t1_frame", 32'(bus.frame), 1);
      check("t1_ack_low", 32'(bus.ack), 0);
      check("t1_pl_low", 32'(bus.pl), 0);
    end
    check("t1_done", 32'(bus.done), 1);
    @(negedge clk);
    check("t1_guard_busy", 32'(bus.busy), 1);
    check("t1_guard_gnt", 32'(bus.gnt), 0);
    @(negedge clk);
    check("t1_idle_busy", 32'(bus.busy), 0);
    check("t1_frames", 32'(frames_done), 32'(base + 1));

    // Simultaneous requests and fairness over 4 frames, from a fresh pointer
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = frames_done;
    bus.data_in = {4'h5, 4'hA};
    exp_q.push_back({2'b01, 4'hA});
    exp_q.push_back({2'b10, 4'h5});
    exp_q.push_back({2'b01, 4'hA});
    exp_q.push_back({2'b10, 4'h5});
    bus.req = 2'b11;
    wait_ack(c0);
    wait_ack(c1);
    check("t2_period_1", 32'(c1 - c0), 7);
    wait_ack(c2);
    check("t2_period_2", 32'(c2 - c1), 7);
    wait_ack(c3);
    bus.req = '0;
    check("t2_period_3", 32'(c3 - c2), 7);
    wait_frames(base + 4);

    // Request dropped mid-frame
    base = frames_done;
    bus.data_in[0 +: W] = 4'h3;
    exp_q.push_back({2'b01, 4'h3});
    bus.req = 2'b01;
    wait_ack(c0);
    @(negedge clk);
    @(negedge clk);
    check("t4_cnt1_idx", 32'(bus.bit_idx), 2);
    bus.req = '0;
    wait_frames(base + 1);
    acks = ack_count;
    repeat (10) @(negedge clk);
    check("t4_no_regrant", 32'(ack_count), 32'(acks));
    check("t4_idle", 32'(bus.busy), 0);

    // Reset mid-frame
    bus.data_in[W +: W] = 4'hC;
    exp_q.push_back({2'b10, 4'hC});
    bus.req = 2'b10;
    wait_ack(c0);
    repeat (3) @(negedge clk);
    check("t5_cnt2_idx", 32'(bus.bit_idx), 1);
    #2 rst = 1'b1;
    #1 check_zero("t5_async");
    exp_q.delete();
    base = frames_done;
    exp_q.push_back({2'b10, 4'hC});
    @(negedge clk);
    rst = 1'b0;
    wait_ack(c0);
    bus.req = '0;
    wait_frames(base + 1);

    // Input change after capture
    base = frames_done;
    bus.data_in[0 +: W] = 4'h6;
    exp_q.push_back({2'b01, 4'h6});
    bus.req = 2'b01;
    wait_ack(c0);
    bus.data_in[0 +: W] = 4'h9;
    bus.req = '0;
    @(negedge clk);
    check("t6_a_hold_1", 32'(bus.a), 32'h6);
    @(negedge clk);
    check("t6_a_hold_2", 32'(bus.a), 32'h6);
    wait_frames(base + 1);
    repeat (3) @(negedge clk);
    check("t6_a_after", 32'(bus.a), 32'h6);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
